// File: rtl/imem_boot_loader.sv
// Boot loader for the 256-word instruction memory: assembles a byte-serial
// host stream into big-endian 32-bit words and drives the memory write port.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   load_start        one-cycle load request, honoured only in IDLE
//   load_len          words to load (1..DEPTH), sampled with load_start
//   abort             cancels a load in progress (RECV or WRITE)
//   byte_valid        host byte available
//   byte_data         host byte
//   byte_ready        loader accepts a byte this cycle
//   mem_we            instruction memory write enable
//   mem_waddr         word index being written
//   mem_wdata         word being written
//   cpu_stall         freezes the core while memory contents are invalid
//   busy              high while receiving or writing
//   done              one-cycle pulse when a load completes
//   error             sticky fault (illegal length or abort)

`timescale 1ns/1ps

module imem_boot_loader #(
    parameter int DEPTH      = 256,
    parameter int AW         = 8,
    parameter bit BOOT_STALL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          abort,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_stall,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    typedef logic [AW:0]   len_t;
    typedef logic [AW-1:0] idx_t;

    localparam len_t MAX_LEN = len_t'(DEPTH);

    state_t      state;
    state_t      state_nxt;

    len_t        len_q;
    idx_t        index;
    logic [1:0]  count;
    logic [31:0] word;
    logic        stall_q;
    logic        error_q;

    logic        len_ok;
    logic        take;
    logic        last_word;

    assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
    assign take      = byte_valid && (state == RECV);
    // Widen the index by one bit so load_len == DEPTH compares cleanly.
    assign last_word = ({1'b0, index} == (len_q - len_t'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start && len_ok) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (take && (count == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // The write still lands even when abort arrives here.
                mem_we = 1'b1;
                busy   = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_word) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RECV;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            index   <= '0;
            count   <= '0;
            word    <= '0;
            stall_q <= BOOT_STALL;
            error_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            len_q   <= load_len;
                            index   <= '0;
                            count   <= '0;
                            error_q <= 1'b0;
                            stall_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (abort) begin
                        error_q <= 1'b1;
                        count   <= '0;
                    end else if (byte_valid) begin
                        word  <= {word[23:0], byte_data};
                        count <= count + 2'd1;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        error_q <= 1'b1;
                        count   <= '0;
                    end else if (!last_word) begin
                        index <= index + idx_t'(1);
                        count <= '0;
                    end
                end
                DONE: begin
                    stall_q <= 1'b0;
                end
                default: begin
                    stall_q <= stall_q;
                end
            endcase
        end
    end

    assign mem_waddr = index;
    assign mem_wdata = word;
    assign cpu_stall = stall_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: load sequences, illegal lengths,
// abort, full-depth load and reset during a load.

`timescale 1ns/1ps

module tb_imem_boot_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          abort;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_stall;
    logic          busy;
    logic          done;
    logic          error;

    int vectors     = 0;
    int miscompares = 0;

    imem_boot_loader #(
        .DEPTH(DEPTH),
        .AW(AW),
        .BOOT_STALL(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_start(load_start),
        .load_len(load_len),
        .abort(abort),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .mem_we(mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int          cyc       = 0;
    int          wr_cnt    = 0;
    int          acc_cnt   = 0;
    int          acc_last  = 0;
    int          done_cnt  = 0;
    int          done_last = 0;
    logic [7:0]  wr_addr   = '0;
    logic [31:0] wr_data   = '0;
    logic [31:0] img [0:DEPTH-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            wr_cnt         <= wr_cnt + 1;
            wr_addr        <= mem_waddr;
            wr_data        <= mem_wdata;
            img[mem_waddr] <= mem_wdata;
        end
        if (byte_valid && byte_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_last <= cyc;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_last <= cyc;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [AW:0] len);
        load_start = 1'b1;
        load_len   = len;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offer one byte and return on the negedge after it is taken.
    task automatic push(input logic [7:0] b);
        bit taken;
        taken      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !taken; i++) begin
            if (byte_ready) taken = 1'b1;
            @(negedge clk);
        end
        if (!taken) chk1("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic push_gap(input logic [7:0] b);
        byte_valid = 1'b0;
        @(negedge clk);
        push(b);
    endtask

    task automatic push_word(input logic [31:0] w);
        push(w[31:24]);
        push(w[23:16]);
        push(w[15:8]);
        push(w[7:0]);
    endtask

    initial begin
        int w0;
        int a0;
        int ac0;
        int dc0;
        logic [31:0] w;

        rst_n      = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;

        // Reset state
        #12;
        chk1("rst_stall", cpu_stall, 1'b1);
        chk1("rst_ready", byte_ready, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk32("rst_waddr", 32'(mem_waddr), 32'h0);
        chk32("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("idle_stall", cpu_stall, 1'b1);
        chk1("idle_busy", busy, 1'b0);

        // Two words, back-to-back bytes
        w0 = wr_cnt;
        start(9'd2);
        chk1("t2_busy", busy, 1'b1);
        chk1("t2_ready", byte_ready, 1'b1);
        push(8'h20);
        a0 = acc_last;
        push(8'h09);
        push(8'h00);
        push(8'h05);
        chk1("t2_we0", mem_we, 1'b1);
        chk32("t2_addr0", 32'(mem_waddr), 32'd0);
        chk32("t2_data0", mem_wdata, 32'h20090005);
        chk1("t2_ready_wr", byte_ready, 1'b0);
        push_word(32'h214A0005);
        byte_valid = 1'b0;
        chk1("t2_we1", mem_we, 1'b1);
        chk32("t2_addr1", 32'(mem_waddr), 32'd1);
        chk32("t2_data1", mem_wdata, 32'h214A0005);
        @(negedge clk);
        chk1("t2_done", done, 1'b1);
        chk1("t2_busy_done", busy, 1'b0);
        chk1("t2_stall_done", cpu_stall, 1'b1);
        @(negedge clk);
        chk1("t2_done_low", done, 1'b0);
        chk1("t2_stall_low", cpu_stall, 1'b0);
        chk32("t2_latency", 32'(done_last - a0), 32'd10);
        chk32("t2_writes", 32'(wr_cnt - w0), 32'd2);
        chk32("t2_img0", img[0], 32'h20090005);
        chk32("t2_img1", img[1], 32'h214A0005);

        // One word, byte_valid toggling
        w0 = wr_cnt;
        start(9'd1);
        push_gap(8'h8C);
        push_gap(8'h08);
        push_gap(8'h00);
        push_gap(8'h04);
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        ac0 = acc_cnt;
        chk1("t3_ready_wr", byte_ready, 1'b0);
        chk1("t3_we", mem_we, 1'b1);
        chk32("t3_addr", 32'(mem_waddr), 32'd0);
        chk32("t3_data", mem_wdata, 32'h8C080004);
        @(negedge clk);
        chk1("t3_done", done, 1'b1);
        chk1("t3_ready_done", byte_ready, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk32("t3_no_accept", 32'(acc_cnt - ac0), 32'd0);
        chk32("t3_writes", 32'(wr_cnt - w0), 32'd1);
        chk32("t3_wdata", wr_data, 32'h8C080004);
        chk1("t3_stall", cpu_stall, 1'b0);

        // Illegal lengths, then a legal start clears error
        w0 = wr_cnt;
        start(9'd0);
        chk1("t4_err0", error, 1'b1);
        chk1("t4_busy0", busy, 1'b0);
        chk1("t4_ready0", byte_ready, 1'b0);
        chk1("t4_stall0", cpu_stall, 1'b0);
        start(9'd257);
        chk1("t4_err257", error, 1'b1);
        chk1("t4_busy257", busy, 1'b0);
        repeat (2) @(negedge clk);
        chk32("t4_writes", 32'(wr_cnt - w0), 32'd0);
        start(9'd3);
        chk1("t4_err_clr", error, 1'b0);
        chk1("t4_busy", busy, 1'b1);
        chk1("t4_stall", cpu_stall, 1'b1);

        // Abort after six bytes of a three-word load
        push_word(32'h01020304);
        push(8'h05);
        push(8'h06);
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_error", error, 1'b1);
        chk1("t5_stall", cpu_stall, 1'b1);
        chk1("t5_ready", byte_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk32("t5_writes", 32'(wr_cnt - w0), 32'd1);
        chk32("t5_addr", 32'(wr_addr), 32'd0);
        chk32("t5_data", wr_data, 32'h01020304);

        // Full-depth load with a stray load_start mid-stream
        w0  = wr_cnt;
        dc0 = done_cnt;
        start(9'd256);
        chk1("t6_err_clr", error, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            w = 32'hC0DE0000 | 32'(k);
            if (k == 100) begin
                load_start = 1'b1;
                load_len   = 9'd5;
            end
            push(w[31:24]);
            load_start = 1'b0;
            push(w[23:16]);
            push(w[15:8]);
            push(w[7:0]);
        end
        byte_valid = 1'b0;
        chk1("t6_we", mem_we, 1'b1);
        chk32("t6_addr", 32'(mem_waddr), 32'd255);
        chk32("t6_data", mem_wdata, 32'hC0DE00FF);
        @(negedge clk);
        chk1("t6_done", done, 1'b1);
        @(negedge clk);
        chk1("t6_stall", cpu_stall, 1'b0);
        chk1("t6_error", error, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        chk32("t6_writes", 32'(wr_cnt - w0), 32'd256);
        chk32("t6_last", 32'(wr_addr), 32'd255);
        chk32("t6_dones", 32'(done_cnt - dc0), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            chk32("t6_img", img[k], 32'hC0DE0000 | 32'(k));
        end

        // Reset during a load
        w0 = wr_cnt;
        start(9'd2);
        push(8'h11);
        push(8'h22);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t7_busy", busy, 1'b0);
        chk1("t7_ready", byte_ready, 1'b0);
        chk1("t7_stall", cpu_stall, 1'b1);
        chk32("t7_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk32("t7_writes", 32'(wr_cnt - w0), 32'd0);
        chk1("t7_error", error, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
